rx_fifo: RTL and testbench
==========================

Name: rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART serial receiver.
- Drains received bytes from the receiver through its data/rda/rec_enable handshake, so the receiver re-arms quickly and line bytes are not lost while the processor is busy.
- Presents a first-word-fall-through read port, an occupancy count, a threshold interrupt and a sticky overrun flag to the processor bus logic.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.
- THRESH, 1, irq asserts when count >= THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- rx_data  input  8  byte from receiver; valid while rx_rda=1.
- rx_rda  input  1  receiver has a byte ready.
- rx_rec_enable  output  1  one-clock pulse that pops the receiver; the receiver clears rda at the same edge.
- rd_data  output  8  head entry; valid when rd_valid=1, undefined content otherwise.
- rd_valid  output  1  FIFO not empty.
- rd_en  input  1  processor consumes head this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- irq  output  1  count>=THRESH.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  clears ovr.

Behaviour:
- Reset (rst=0 at posedge), which overrides everything:
  - wr_ptr=0, rd_ptr=0, count=0, rx_rec_enable=0, ovr=0.
  - Outputs therefore read rd_valid=0, full=0, irq=0.
  - Memory contents are not cleared.
  - Reset mid-transfer discards all buffered bytes; no rx_rec_enable pulse is issued in the reset cycle.
- Capture condition, evaluated every cycle: cap = rx_rda & ~rx_rec_enable. The registered rx_rec_enable blocks a second capture of the same byte in the cycle after the pop.
- When cap=1 at edge N:
  - rx_rec_enable=1 during cycle N+1 only.
  - Pulses are therefore never back-to-back.
- Pop: pop = rd_en & rd_valid. rd_en while empty is ignored and leaves pointers and count unchanged.
- Push acceptance: push = cap & (~full | pop).
  - Simultaneous push and pop at full are both accepted; count stays DEPTH.
- Drop on full: cap & full & ~pop:
  - The byte is still popped from the receiver (rx_rec_enable pulses) and discarded.
  - ovr sets to 1 at the same edge.
  - Memory, wr_ptr and count are unchanged.
- On push: mem[wr_ptr]<=rx_data, wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- On pop: rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged.
- rd_data = mem[rd_ptr]; rd_data and rd_valid are combinational from the registered pointers and count.
- Latency: byte captured at edge N appears with rd_valid=1 and on rd_data in cycle N+1.
  - A push into an empty FIFO while rd_en=1 is not popped that cycle, because rd_valid was 0.
- Full-to-empty: a pop at count=1 with no push gives rd_valid=0 next cycle.
- ovr_clr: ovr<=0, except when a drop occurs in the same cycle; set wins, and ovr stays 1.
- full, irq and rd_valid are pure decodes of count. No other state machine is needed beyond the pointers, count and the rx_rec_enable register.

Test Plan:
- Reset behaviour: hold rst=0 for 3 clk with rx_rda=1 -> rx_rec_enable=0, count=0, rd_valid=0, ovr=0 throughout. Release -> rx_rec_enable pulses exactly one cycle later.
- Single byte: rx_rda=1, rx_data=0xA5; model the receiver clearing rda after the pop -> exactly one rx_rec_enable pulse, next cycle rd_valid=1, rd_data=0xA5, count=1, irq=1. Then rd_en for 1 cycle -> count=0, rd_valid=0.
- Fill and wrap: push 0x01..0x08 -> full=1, count=8. Pop 3 and push 0x09..0x0B -> the sequence popped is 0x04..0x0B, in order, with pointer wrap and no corruption.
- Overrun: at full, the receiver offers 0x55 -> rx_rec_enable pulses, count stays 8, ovr=1, head unchanged. ovr_clr pulse -> ovr=0. Drop coincident with ovr_clr -> ovr=1.
- Simultaneous push and pop at full: rd_en=1 in the capture cycle of 0x77 -> count stays 8, ovr=0, 0x77 is read last.
- Edge cases: rd_en while empty -> no state change. Reset asserted with count=5 -> count=0 next cycle, and the subsequent byte 0x3C reads back as the first entry.

Source files
------------

// File: rtl/rx_fifo.sv
// rx_fifo: receive-side byte buffer between the UART receiver and the
// processor bus. Drains the receiver through its rda/rec_enable handshake,
// offers a first-word-fall-through read port with occupancy, a threshold
// interrupt and a sticky overrun flag.
module rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rda,
    output logic              rx_rec_enable,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_en,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              irq,
    output logic              ovr,
    input  logic              ovr_clr
);

    localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_CNT = (ADDR_W + 1)'(THRESH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic cap;
    logic pop;
    logic push;
    logic drop;

    // Status flags are pure decodes of the occupancy counter.
    assign rd_valid = (count != '0);
    assign full     = (count == DEPTH_CNT);
    assign irq      = (count >= THRESH_CNT);

    // Head of the queue falls straight through to the read port.
    assign rd_data  = mem[rd_ptr];

    // The registered rec_enable masks the byte that is being popped this
    // cycle, since the receiver only drops rda at the end of the pulse.
    assign cap  = rx_rda & ~rx_rec_enable;
    assign pop  = rd_en & rd_valid;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    // Pointers, occupancy, handshake pulse and overrun flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rx_rec_enable <= 1'b0;
            ovr           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value of the others, independent of statement order.
            rx_rec_enable <= cap;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    // Byte storage; written only on an accepted push outside reset.
    // NOTE: the storage array has no reset on purpose -- stale entries are
    // unreachable once the pointers and count are cleared, and leaving it
    // out lets the array map onto plain RAM or cheap flops.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed plus randomized checks of rx_fifo against a
// queue-based model of the buffer and a model of the UART receiver side.
module tb_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int THRESH = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_rda;
    logic              rx_rec_enable;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_en;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              irq;
    logic              ovr;
    logic              ovr_clr;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered bytes, expected pulse and flag.
    logic [7:0] q[$];
    logic       m_rec;
    logic       m_ovr;

    always #5 clk = ~clk;

    rx_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .THRESH(THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rda       (rx_rda),
        .rx_rec_enable(rx_rec_enable),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_en        (rd_en),
        .count        (count),
        .full         (full),
        .irq          (irq),
        .ovr          (ovr),
        .ovr_clr      (ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rec_enable", 32'(rx_rec_enable), 32'(m_rec));
        chk("count", 32'(count), 32'(q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("irq", 32'(irq), 32'(q.size() >= THRESH));
        chk("ovr", 32'(ovr), 32'(m_ovr));
        if (q.size() != 0) begin
            chk("rd_data", 32'(rd_data), 32'(q[0]));
        end
    endtask

    // One clock: update the model from the pre-edge inputs, advance the DUT,
    // let the receiver react to the pulse it saw, then compare.
    task automatic cycle();
        logic rec_before;
        logic cap;
        logic pop;
        logic drop;
        rec_before = m_rec;
        if (!rst) begin
            q.delete();
            m_rec = 1'b0;
            m_ovr = 1'b0;
        end else begin
            cap = rx_rda && !m_rec;
            pop = rd_en && (q.size() != 0);
            if (pop) void'(q.pop_front());
            drop = cap && (q.size() >= DEPTH);
            if (cap && !drop) q.push_back(rx_data);
            if (drop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            m_rec = cap;
        end
        @(posedge clk);
        // The receiver clears rda at the edge that ends the pop pulse.
        if (rec_before) rx_rda = 1'b0;
        #1;
        check_all();
    endtask

    // Receiver offers one byte and holds it until popped (bounded wait).
    task automatic offer(input logic [7:0] b);
        rx_data = b;
        rx_rda  = 1'b1;
        for (int i = 0; i < 8 && rx_rda; i++) cycle();
        if (rx_rda) begin
            chk("offer_timeout", 32'(rx_rda), 32'd0);
            rx_rda = 1'b0;
        end
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] b);
        chk(tag, 32'(rd_data), 32'(b));
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        rx_data = 8'h11;
        rx_rda  = 1'b1;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
        q.delete();
        m_rec = 1'b0;
        m_ovr = 1'b0;
        #1;

        // Reset held with a byte on offer: no pulse, everything empty.
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_count", 32'(count), 32'd0);
        rst = 1'b1;
        cycle();
        chk("pulse_after_release", 32'(rx_rec_enable), 32'd1);
        cycle();
        chk("pulse_one_cycle", 32'(rx_rec_enable), 32'd0);
        pop_expect("reset_release_byte", 8'h11);

        // Single byte round trip.
        offer(8'hA5);
        chk("single_data", 32'(rd_data), 32'hA5);
        chk("single_count", 32'(count), 32'd1);
        chk("single_irq", 32'(irq), 32'd1);
        pop_expect("single_pop", 8'hA5);
        chk("single_empty", 32'(rd_valid), 32'd0);

        // Fill, partial drain, refill across the pointer wrap.
        for (int i = 1; i <= 8; i++) offer(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        for (int i = 1; i <= 3; i++) pop_expect("fill_pop", 8'(i));
        for (int i = 9; i <= 11; i++) offer(8'(i));
        chk("wrap_full", 32'(full), 32'd1);

        // Overrun: byte still popped from receiver, discarded, flag set.
        offer(8'h55);
        chk("ovr_count", 32'(count), 32'd8);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_head", 32'(rd_data), 32'h04);
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(ovr), 32'd0);

        // Drop coincident with clear: set wins.
        rx_data = 8'h66;
        rx_rda  = 1'b1;
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        chk("ovr_set_wins", 32'(ovr), 32'd1);
        cycle();
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;

        // Simultaneous push and pop at full.
        chk("sim_head", 32'(rd_data), 32'h04);
        rx_data = 8'h77;
        rx_rda  = 1'b1;
        rd_en   = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("sim_count", 32'(count), 32'd8);
        chk("sim_ovr", 32'(ovr), 32'd0);
        cycle();
        for (int i = 5; i <= 11; i++) pop_expect("drain_seq", 8'(i));
        pop_expect("drain_last", 8'h77);
        chk("drain_empty", 32'(rd_valid), 32'd0);

        // rd_en while empty changes nothing.
        rd_en = 1'b1;
        cycle();
        cycle();
        rd_en = 1'b0;
        chk("empty_rd_count", 32'(count), 32'd0);

        // Push into empty while rd_en is high is not popped that cycle.
        rd_en   = 1'b1;
        rx_data = 8'h9E;
        rx_rda  = 1'b1;
        cycle();
        chk("empty_push_kept", 32'(count), 32'd1);
        cycle();
        rd_en = 1'b0;

        // Reset with five buffered bytes discards them.
        for (int i = 0; i < 5; i++) offer(8'(8'hC0 + i));
        chk("pre_reset_count", 32'(count), 32'd5);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("mid_reset_count", 32'(count), 32'd0);
        offer(8'h3C);
        chk("post_reset_head", 32'(rd_data), 32'h3C);
        pop_expect("post_reset_pop", 8'h3C);

        // Randomized traffic, first biased toward filling then draining.
        for (int i = 0; i < 3000; i++) begin
            if (!rx_rda && $urandom_range(0, 99) < 60) begin
                rx_rda  = 1'b1;
                rx_data = 8'($urandom);
            end
            rd_en   = ($urandom_range(0, 99) < ((i < 1500) ? 25 : 70));
            ovr_clr = ($urandom_range(0, 99) < 5);
            rst     = !($urandom_range(0, 999) < 5);
            cycle();
        end
        rst     = 1'b1;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
